// File: rtl/cq_arb_pkg.sv
// cq_arb_pkg: shared CQ widths, arbiter state type and the
// round-robin index wrap helper used by cq_pio_arbiter/rr_pick.
package cq_arb_pkg;

  localparam int CQ_DATA_W = 64;
  localparam int CQ_USER_W = 85;
  localparam int CQ_KEEP_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // idx is assumed < 2*n (pointer plus offset).
  function automatic int unsigned rr_wrap(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/cq_pio_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner select.
// Ports: req (request vector), ptr (first index to scan),
//        winner (first set req at/after ptr), any_req.
module rr_pick
  import cq_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any_req
);

  logic [W-1:0] idx;
  logic         found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = W'(rr_wrap(32'(ptr) + 32'(i),
                       32'(N)));
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/cq_pio_arbiter.sv
// cq_pio_arbiter: packet-granular round-robin arbiter sharing the
// PCIe CQ AXI-stream into eth_top between NUM_REQ PIO requesters.
// Ports: user_clk, reset (sync, active-high);
//   s_cq_* : packed requester streams (req i at slice i);
//   m_cq_* : muxed stream to eth_top, m_cq_tready single bit;
//   grant_id : current/last owner; wdog_err : forced-release pulse;
//   pkt_cnt : per-requester tlast counters (CQ_ARB_STATS_EN only).
module cq_pio_arbiter
  import cq_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int C_DATA_WIDTH = CQ_DATA_W,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
  parameter int USER_WIDTH   = CQ_USER_W,
  parameter int MAX_BEATS    = 16,
  localparam int GW = $clog2(NUM_REQ),
  localparam int BW = $clog2(MAX_BEATS + 1)
) (
  input  logic                          user_clk,
  input  logic                          reset,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0] s_cq_tdata,
  input  logic [NUM_REQ*USER_WIDTH-1:0] s_cq_tuser,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0] s_cq_tkeep,
  input  logic [NUM_REQ-1:0]            s_cq_tlast,
  input  logic [NUM_REQ-1:0]            s_cq_tvalid,
  output logic [NUM_REQ-1:0]            s_cq_tready,
  output logic [C_DATA_WIDTH-1:0]       m_cq_tdata,
  output logic [USER_WIDTH-1:0]         m_cq_tuser,
  output logic [KEEP_WIDTH-1:0]         m_cq_tkeep,
  output logic                          m_cq_tlast,
  output logic                          m_cq_tvalid,
  input  logic                          m_cq_tready,
  output logic [GW-1:0]                 grant_id,
  output logic                          wdog_err
`ifdef CQ_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]         pkt_cnt
`endif
);

  arb_state_t state, state_nx;

  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] pick;
  logic          any_req;
  logic [BW-1:0] beat_cnt;
  logic          xfer;
  logic          wdog_hit;

  logic [C_DATA_WIDTH-1:0] dat  [NUM_REQ];
  logic [USER_WIDTH-1:0]   usr  [NUM_REQ];
  logic [KEEP_WIDTH-1:0]   kep  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign dat[g] =
      s_cq_tdata[g*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign usr[g] =
      s_cq_tuser[g*USER_WIDTH +: USER_WIDTH];
    assign kep[g] =
      s_cq_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH];
  end

  rr_pick #(
    .N (NUM_REQ),
    .W (GW)
  ) u_pick (
    .req     (s_cq_tvalid),
    .ptr     (rr_ptr),
    .winner  (pick),
    .any_req (any_req)
  );

  // Payload always follows the owner; only tvalid is gated.
  assign m_cq_tdata = dat[grant_id];
  assign m_cq_tuser = usr[grant_id];
  assign m_cq_tkeep = kep[grant_id];
  assign m_cq_tlast = s_cq_tlast[grant_id];

  assign xfer = m_cq_tvalid & m_cq_tready;

  // MAX_BEATS-th beat accepted without tlast: force release.
  assign wdog_hit = xfer & ~m_cq_tlast &
                    (beat_cnt == BW'(MAX_BEATS - 1));

  always_ff @(posedge user_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (any_req) state_nx = BUSY;
      BUSY: if (xfer && (m_cq_tlast || wdog_hit))
              state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    m_cq_tvalid = 1'b0;
    s_cq_tready = '0;
    if (state == BUSY) begin
      m_cq_tvalid           = s_cq_tvalid[grant_id];
      s_cq_tready[grant_id] = m_cq_tready;
    end
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      wdog_err <= wdog_hit;
      if (state == IDLE && any_req)
        grant_id <= pick;
      if (xfer) begin
        if (m_cq_tlast || wdog_hit) begin
          beat_cnt <= '0;
          rr_ptr   <= GW'(rr_wrap(32'(grant_id) + 32'd1,
                                  32'(NUM_REQ)));
        end else if (beat_cnt != BW'(MAX_BEATS)) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

`ifdef CQ_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [31:0] cnt;
    always_ff @(posedge user_clk) begin
      if (reset)
        cnt <= '0;
      else if (xfer && m_cq_tlast &&
               grant_id == GW'(g))
        cnt <= cnt + 32'd1;
    end
    assign pkt_cnt[g*32 +: 32] = cnt;
  end
`endif

endmodule

// File: doc/cq_pio_arbiter.md
Name: cq_pio_arbiter

Overview:
- Packet-granular round-robin arbiter. Shares the single PCIe completer-request (CQ) AXI-stream into eth_top between NUM_REQ PIO requesters (host_pio_wr instances, DMA-doorbell sources).
- Sits between the requesters and eth_top's m_axis_cq_* inputs.
- A grant is held from the first beat through the tlast beat, so TLPs are never interleaved.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- C_DATA_WIDTH, 64, CQ tdata width.
- KEEP_WIDTH, C_DATA_WIDTH/32, CQ tkeep width.
- USER_WIDTH, 85, CQ tuser width.
- MAX_BEATS, 16, per-packet beat limit before forced release (watchdog).

Ports:
- user_clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_cq_tdata  in  NUM_REQ*C_DATA_WIDTH  requester data, req i at slice i.
- s_cq_tuser  in  NUM_REQ*USER_WIDTH  requester tuser.
- s_cq_tkeep  in  NUM_REQ*KEEP_WIDTH  requester tkeep.
- s_cq_tlast  in  NUM_REQ  requester tlast.
- s_cq_tvalid  in  NUM_REQ  requester tvalid.
- s_cq_tready  out  NUM_REQ  requester tready.
- m_cq_tdata  out  C_DATA_WIDTH  to eth_top.
- m_cq_tuser  out  USER_WIDTH  to eth_top.
- m_cq_tkeep  out  KEEP_WIDTH  to eth_top.
- m_cq_tlast  out  1  to eth_top.
- m_cq_tvalid  out  1  to eth_top.
- m_cq_tready  in  1  from eth_top (single bit; the top level replicates it to the 22-bit bus).
- grant_id  out  $clog2(NUM_REQ)  current or last owner.
- wdog_err  out  1  one-cycle pulse on forced release.

Behaviour:
- States: IDLE, BUSY.
- Reset values: state=IDLE, grant_id=0, rr pointer=0 (req 0 highest priority first), beat_cnt=0, wdog_err=0, all s_cq_tready=0, m_cq_tvalid=0.
- IDLE, no tvalid: stay in IDLE; m_cq_tvalid=0; all tready=0.
- IDLE, any tvalid: pick the first valid requester at or after the rr pointer (wrapping NUM_REQ-1 -> 0). Register grant_id, go to BUSY. No data moves in the decision cycle, so latency is 1 cycle from tvalid to m_cq_tvalid.
- BUSY datapath: combinational mux. m_cq_* = slice[grant_id]; s_cq_tready[grant_id] = m_cq_tready; all other tready=0.
- Beat transfer: m_cq_tvalid & m_cq_tready. Each transfer increments beat_cnt.
- On a tlast transfer: return to IDLE, rr pointer = grant_id+1 mod NUM_REQ, beat_cnt=0.
- Back-to-back: no combinational re-grant. A minimum 1 idle cycle separates packets.
- Watchdog: when beat_cnt reaches MAX_BEATS with a non-tlast beat transferred, pulse wdog_err, force IDLE, advance the rr pointer. The remainder of that packet is treated as a new packet later (corruption flagged, not hidden).
- Granted requester drops tvalid mid-packet: hold the grant. Stalls are legal.
- m_cq_tready low: hold everything. beat_cnt does not advance.
- Reset mid-packet: immediate IDLE, all outputs return to reset values on the next edge. A partial TLP may have reached eth_top; its recovery is that block's concern.
- beat_cnt width: $clog2(MAX_BEATS+1), saturating. It never wraps.

Optional Feature:
- Macro: CQ_ARB_STATS_EN.
- Defined: adds output pkt_cnt (NUM_REQ*32). One 32-bit counter per requester increments on each tlast transfer from that requester. Counters wrap at 2^32 and are cleared by reset. Watchdog-released packets are not counted.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package cq_arb_pkg:
  - Width constants CQ_DATA_W=64, CQ_USER_W=85, CQ_KEEP_W=2.
  - State enum arb_state_t {IDLE, BUSY}.
  - Function for the round-robin index wrap.
- Sub-module rr_pick: combinational. Inputs are the request vector and rr pointer; outputs are the winner index and any_req. Reused later for the CC-side arbiter.

Test Plan:
- Reset, then req0 sends a 3-beat TLP (tdata 0x1111.., 0x2222.., 0x3333.., tlast on beat 3), m_cq_tready=1 -> m_cq_tvalid rises 1 cycle after s_cq_tvalid[0], 3 beats out in order, grant_id=0, state IDLE after beat 3.
- req0 and req1 both valid continuously with 2-beat packets -> grants alternate 0,1,0,1. Each packet is contiguous with one idle cycle between packets. No beat of req1 appears inside a req0 packet.
- m_cq_tready toggled 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated, s_cq_tready[granted] mirrors m_cq_tready, other tready stay 0.
- MAX_BEATS=4, req1 sends 6 beats without tlast -> wdog_err pulses once after beat 4, grant moves to req0 if it is valid.
- Assert reset while grant_id=1 in mid-packet -> next cycle m_cq_tvalid=0, all tready=0, grant_id=0, and req0 wins the next arbitration.
- With CQ_ARB_STATS_EN: 5 packets from req0 and 3 from req1 -> pkt_cnt[0]=5, pkt_cnt[1]=3. Reset clears both to 0.
